// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit masks, leading-zero
// blanking and frame-synchronous (tear-free) application of written display data.
module seg_scan_ctrl #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [4*DIGITS-1:0]   wr_data_i,
    input  logic [DIGITS-1:0]     wr_dp_i,
    input  logic [DIGITS-1:0]     wr_mask_i,
    input  logic                  wr_lzb_i,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int TW = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] EN_OFF    = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [TW-1:0]       tick_r;
    logic [IW-1:0]       idx_r;
    logic                frame_r;
    logic                pending_r;
    logic [4*DIGITS-1:0] stg_data_r, shd_data_r;
    logic [DIGITS-1:0]   stg_dp_r, shd_dp_r;
    logic [DIGITS-1:0]   stg_mask_r, shd_mask_r;
    logic                stg_lzb_r, shd_lzb_r;
    logic [DIGITS-1:0]   en_r;
    logic [6:0]          seg_r;
    logic                dp_r;

    logic                wrap_s;
    logic                boundary_s;
    logic [DIGITS-1:0]   zero_above_s;
    logic [3:0]          nib_s;
    logic                blank_s;
    logic [DIGITS-1:0]   en_s;
    logic [6:0]          seg_s;
    logic                dp_s;

    assign wrap_s     = (tick_r == TICK_LAST);
    assign boundary_s = wrap_s && (idx_r == IDX_LAST);

    // Scan timebase: slot tick counter, digit index and frame pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_r  <= '0;
            idx_r   <= '0;
            frame_r <= 1'b0;
        end else begin
            frame_r <= boundary_s;
            if (wrap_s) begin
                tick_r <= '0;
                idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
            end else begin
                tick_r <= tick_r + TW'(1);
            end
        end
    end

    // Staging of writes; shadow only loads on a frame boundary, a boundary write bypasses staging
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r  <= 1'b0;
            stg_data_r <= '0;
            stg_dp_r   <= '0;
            stg_mask_r <= '0;
            stg_lzb_r  <= 1'b0;
            shd_data_r <= '0;
            shd_dp_r   <= '0;
            shd_mask_r <= '0;
            shd_lzb_r  <= 1'b0;
        end else if (boundary_s) begin
            pending_r <= 1'b0;
            if (wr_en_i) begin
                shd_data_r <= wr_data_i;
                shd_dp_r   <= wr_dp_i;
                shd_mask_r <= wr_mask_i;
                shd_lzb_r  <= wr_lzb_i;
            end else if (pending_r) begin
                shd_data_r <= stg_data_r;
                shd_dp_r   <= stg_dp_r;
                shd_mask_r <= stg_mask_r;
                shd_lzb_r  <= stg_lzb_r;
            end
        end else if (wr_en_i) begin
            pending_r  <= 1'b1;
            stg_data_r <= wr_data_i;
            stg_dp_r   <= wr_dp_i;
            stg_mask_r <= wr_mask_i;
            stg_lzb_r  <= wr_lzb_i;
        end
    end

    // zero_above_s[k]: nibble k and every nibble above it are zero
    always_comb begin
        logic run;
        run          = 1'b1;
        zero_above_s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run             = run && (shd_data_r[4*k +: 4] == 4'h0);
            zero_above_s[k] = run;
        end
    end

    // Active-high view of the current slot, from shadow data only
    always_comb begin
        nib_s   = shd_data_r[{idx_r, 2'b00} +: 4];
        en_s    = '0;
        seg_s   = 7'h00;
        dp_s    = 1'b0;
        blank_s = 1'b0;
        if (shd_lzb_r && (idx_r != '0)) begin
            blank_s = zero_above_s[idx_r];
        end else begin
            blank_s = 1'b0;
        end
        if (shd_mask_r[idx_r]) begin
            en_s[idx_r] = 1'b1;
            dp_s        = shd_dp_r[idx_r];
            if (blank_s) begin
                seg_s = 7'h00;
            end else begin
                seg_s = hex7(nib_s);
            end
        end else begin
            en_s  = '0;
            seg_s = 7'h00;
            dp_s  = 1'b0;
        end
    end

    // Pin registers: all three update on one edge with the board polarity applied
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_r  <= EN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= ACTIVE_LOW;
        end else begin
            en_r  <= en_s ^ EN_OFF;
            seg_r <= seg_s ^ SEG_OFF;
            dp_r  <= dp_s ^ ACTIVE_LOW;
        end
    end

    assign digit_en_o = en_r;
    assign seg_o      = seg_r;
    assign dp_o       = dp_r;
    assign frame_o    = frame_r;
    assign pending_o  = pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model queues the expected
// pin state per cycle; a monitor compares both an active-high and an active-low instance.
module tb_seg_scan_ctrl;

    localparam int D  = 8;
    localparam int S  = 4;
    localparam int SD = D * S;

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
        logic       pending;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic [7:0]  wr_dp_i;
    logic [7:0]  wr_mask_i;
    logic        wr_lzb_i;

    logic [7:0]  en_h, en_l;
    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l, fr_h, fr_l, pd_h, pd_l;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .wr_dp_i(wr_dp_i), .wr_mask_i(wr_mask_i), .wr_lzb_i(wr_lzb_i),
        .digit_en_o(en_h), .seg_o(seg_h), .dp_o(dp_h), .frame_o(fr_h), .pending_o(pd_h)
    );

    seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .wr_dp_i(wr_dp_i), .wr_mask_i(wr_mask_i), .wr_lzb_i(wr_lzb_i),
        .digit_en_o(en_l), .seg_o(seg_l), .dp_o(dp_l), .frame_o(fr_l), .pending_o(pd_l)
    );

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    obs_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: edges since reset, displayed and staged frames
    int          t;
    logic [31:0] m_data, s_data;
    logic [7:0]  m_dp, m_mask, s_dp, s_mask;
    logic        m_lzb, s_lzb, m_pend;

    function automatic obs_t show(input logic [31:0] d, input logic [7:0] dp,
                                  input logic [7:0] mask, input logic lzb, input int slot);
        obs_t        o;
        logic [31:0] upper;
        o     = '0;
        upper = d >> (4 * slot);
        if (mask[slot]) begin
            o.en = 8'(1) << slot;
            o.dp = dp[slot];
            if (lzb && slot > 0 && upper == 32'h0) o.seg = 7'h00;
            else o.seg = hex_tab[upper[3:0]];
        end
        return o;
    endfunction

    always @(posedge clk) begin : model
        obs_t e;
        if (rst_i) begin
            t = 0; m_pend = 1'b0;
            m_data = '0; m_dp = '0; m_mask = '0; m_lzb = 1'b0;
            s_data = '0; s_dp = '0; s_mask = '0; s_lzb = 1'b0;
            e = '0;
        end else begin
            e       = show(m_data, m_dp, m_mask, m_lzb, (t / S) % D);
            e.frame = ((t % SD) == SD - 1);
            if (e.frame) begin
                if (wr_en_i) begin
                    m_data = wr_data_i; m_dp = wr_dp_i; m_mask = wr_mask_i; m_lzb = wr_lzb_i;
                end else if (m_pend) begin
                    m_data = s_data; m_dp = s_dp; m_mask = s_mask; m_lzb = s_lzb;
                end
                m_pend = 1'b0;
            end else if (wr_en_i) begin
                s_data = wr_data_i; s_dp = wr_dp_i; s_mask = wr_mask_i; s_lzb = wr_lzb_i;
                m_pend = 1'b1;
            end
            e.pending = m_pend;
            t++;
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t e, a_h, a_l;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            a_h = {en_h, seg_h, dp_h, fr_h, pd_h};
            a_l = {~en_l, ~seg_l, ~dp_l, fr_l, pd_l};
            total++;
            if (a_h !== e) begin
                bad++;
                $display("FAIL pins_hi @%0t got en=%h seg=%h dp=%b fr=%b pend=%b want en=%h seg=%h dp=%b fr=%b pend=%b",
                         $time, a_h.en, a_h.seg, a_h.dp, a_h.frame, a_h.pending,
                         e.en, e.seg, e.dp, e.frame, e.pending);
            end
            total++;
            if (a_l !== e) begin
                bad++;
                $display("FAIL pins_lo @%0t got en=%h seg=%h dp=%b fr=%b pend=%b want ~en=%h ~seg=%h ~dp=%b fr=%b pend=%b",
                         $time, en_l, seg_l, dp_l, fr_l, pd_l,
                         e.en, e.seg, e.dp, e.frame, e.pending);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] m, input logic [7:0] dp,
                         input logic l);
        @(negedge clk);
        wr_en_i = 1'b1; wr_data_i = d; wr_mask_i = m; wr_dp_i = dp; wr_lzb_i = l;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Drive a write so that it is sampled on the frame boundary edge
    task automatic write_on_boundary(input logic [31:0] d, input logic [7:0] m,
                                     input logic [7:0] dp, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (((t % SD) != SD - 1) && n < 2 * SD) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * SD) begin
            total++;
            bad++;
            $display("FAIL boundary_wait got %0d cycles want < %0d", n, 2 * SD);
        end
        wr_en_i = 1'b1; wr_data_i = d; wr_mask_i = m; wr_dp_i = dp; wr_lzb_i = l;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          sh;
        rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; wr_dp_i = '0; wr_mask_i = '0; wr_lzb_i = 1'b0;
        tick(3);
        rst_i = 1'b0;
        tick(70);
        write(32'h1234_5678, 8'hFF, 8'h01, 1'b0);
        tick(80);
        tick(7);
        write(32'h9ABC_DEF0, 8'hFF, 8'h80, 1'b0);
        tick(3);
        write(32'h0F1E_2D3C, 8'h7E, 8'h18, 1'b0);
        tick(70);
        write(32'h0000_00A0, 8'hFF, 8'h00, 1'b1);
        tick(70);
        write(32'h0000_0000, 8'hFF, 8'h06, 1'b1);
        tick(70);
        write(32'h0000_0000, 8'hF0, 8'h00, 1'b1);
        tick(70);
        write_on_boundary(32'hDEAD_BEEF, 8'hFF, 8'h5A, 1'b0);
        tick(40);
        tick(5);
        write(32'hCAFE_0123, 8'hFF, 8'hFF, 1'b1);
        tick(4);
        pulse_reset();
        tick(40);
        for (int i = 0; i < 80; i++) begin
            tick($urandom_range(0, 40));
            d  = $urandom;
            sh = $urandom_range(0, 32);
            d  = (sh >= 32) ? 32'h0 : (d >> sh);
            if ($urandom_range(0, 5) == 0) begin
                write_on_boundary(d, 8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                write(d, 8'($urandom), 8'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 14) == 0) pulse_reset();
        end
        tick(70);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
